// File: rtl/serial_deserializer_if.sv
// Handshake bundle between the serial deserializer and whatever drives it and consumes its words.
// The master modport is the transmitter/consumer side; the slave modport is the deserializer.
interface serial_deserializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clear;
  logic             sin;
  logic             sin_valid;
  logic             msb_first;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output clear,
    output sin,
    output sin_valid,
    output msb_first,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  clear,
    input  sin,
    input  sin_valid,
    input  msb_first,
    input  dout_ready,
    output dout,
    output dout_valid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words MSB- or LSB-first and hands them
// out through a one-entry holding register with a valid/ready handshake and a sticky overrun flag.
module serial_deserializer #(
  parameter int unsigned WIDTH = 4
) (
  input logic                 i_clk,
  input logic                 i_reset_n,
  serial_deserializer_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_deserializer: WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

  // Input side state
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [CntW-1:0]  r_cnt_q, r_cnt_d;
  logic             r_order_q, r_order_d;

  // Output side state
  out_state_e       r_state_q, r_state_d;
  logic [WIDTH-1:0] r_dout_q, r_dout_d;
  logic             r_overrun_q, r_overrun_d;

  logic             w_first_bit;
  logic             w_order;
  logic             w_complete;
  logic [WIDTH-1:0] w_sr_next;

  assign w_first_bit = (r_cnt_q == '0);
  // The first bit of a word uses the live msb_first; later bits use the value latched with it.
  assign w_order     = w_first_bit ? bus.msb_first : r_order_q;
  assign w_sr_next   = w_order ? {r_sr_q[WIDTH-2:0], bus.sin} : {bus.sin, r_sr_q[WIDTH-1:1]};
  assign w_complete  = bus.sin_valid && (r_cnt_q == CntLast);

  always_comb begin
    r_sr_d    = r_sr_q;
    r_cnt_d   = r_cnt_q;
    r_order_d = r_order_q;
    if (bus.sin_valid) begin
      r_sr_d  = w_sr_next;
      r_cnt_d = w_complete ? '0 : r_cnt_q + CntW'(1);
      if (w_first_bit) begin
        r_order_d = bus.msb_first;
      end
    end
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_dout_d    = r_dout_q;
    r_overrun_d = r_overrun_q;
    unique case (r_state_q)
      StEmpty: begin
        if (w_complete) begin
          r_dout_d  = w_sr_next;
          r_state_d = StFull;
        end
      end
      StFull: begin
        if (w_complete) begin
          if (bus.dout_ready) begin
            r_dout_d = w_sr_next;
          end else begin
            r_overrun_d = 1'b1;
          end
        end else if (bus.dout_ready) begin
          r_state_d = StEmpty;
        end
      end
      default: r_state_d = StEmpty;
    endcase
  end

  // clear acts exactly like reset, with priority over sampling and the handshake
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sr_q      <= '0;
      r_cnt_q     <= '0;
      r_order_q   <= 1'b0;
      r_state_q   <= StEmpty;
      r_dout_q    <= '0;
      r_overrun_q <= 1'b0;
    end else if (bus.clear) begin
      r_sr_q      <= '0;
      r_cnt_q     <= '0;
      r_order_q   <= 1'b0;
      r_state_q   <= StEmpty;
      r_dout_q    <= '0;
      r_overrun_q <= 1'b0;
    end else begin
      r_sr_q      <= r_sr_d;
      r_cnt_q     <= r_cnt_d;
      r_order_q   <= r_order_d;
      r_state_q   <= r_state_d;
      r_dout_q    <= r_dout_d;
      r_overrun_q <= r_overrun_d;
    end
  end

  assign bus.dout       = r_dout_q;
  assign bus.dout_valid = (r_state_q == StFull);
  assign bus.busy       = (r_cnt_q != '0);
  assign bus.overrun    = r_overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: table-driven word vectors plus hand-written
// sequences for overrun, back-to-back transfer and mid-word reset/clear, with a word scoreboard.
module tb_serial_deserializer;
  localparam int unsigned W = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  serial_deserializer_if #(.WIDTH(W)) bus ();

  serial_deserializer #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  typedef struct {
    logic [W-1:0] bits;    // bits[W-1] is transmitted first
    logic         msb;
    int           gap;
    logic         toggle;  // flip msb_first after the first bit
    logic [W-1:0] exp;
  } vec_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] sb[$];
  vec_t         vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sin_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic msb, input logic ready);
    @(negedge clk);
    bus.sin        = b;
    bus.sin_valid  = 1'b1;
    bus.msb_first  = msb;
    bus.dout_ready = ready;
    @(posedge clk);
    #1;
    bus.sin_valid  = 1'b0;
    bus.dout_ready = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] bits, input logic msb, input int gap,
                           input logic toggle, input logic chk_busy, input logic ready_last);
    for (int i = 0; i < W; i++) begin
      logic m;
      m = (toggle && i > 0) ? ~msb : msb;
      send_bit(bits[W-1-i], m, (i == W - 1) ? ready_last : 1'b0);
      if (chk_busy) check("busy", 32'(bus.busy), 32'(i != W - 1));
      if (i < W - 1) idle(gap);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    bus.dout_ready = 1'b1;
    check("accept_valid", 32'(bus.dout_valid), 32'd1);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected a pending word");
    end else begin
      check("accept_dout", 32'(bus.dout), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
    bus.dout_ready = 1'b0;
    check("valid_after_accept", 32'(bus.dout_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1011, 1'b1, 0, 1'b0, 4'b1011};
    vecs[1] = '{4'b1011, 1'b0, 0, 1'b1, 4'b1101};
    vecs[2] = '{4'b1011, 1'b1, 3, 1'b0, 4'b1011};
    vecs[3] = '{4'b1011, 1'b0, 3, 1'b1, 4'b1101};
    vecs[4] = '{4'b0110, 1'b1, 1, 1'b1, 4'b0110};
    vecs[5] = '{4'b1000, 1'b0, 0, 1'b0, 4'b0001};
    vecs[6] = '{4'b0111, 1'b0, 2, 1'b0, 4'b1110};

    bus.clear      = 1'b0;
    bus.sin        = 1'b0;
    bus.sin_valid  = 1'b0;
    bus.msb_first  = 1'b0;
    bus.dout_ready = 1'b0;

    #12;
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      send_word(vecs[k].bits, vecs[k].msb, vecs[k].gap, vecs[k].toggle, 1'b1, 1'b0);
      sb.push_back(vecs[k].exp);
      check("word_valid", 32'(bus.dout_valid), 32'd1);
      check("word_dout", 32'(bus.dout), 32'(sb[0]));
      check("word_overrun", 32'(bus.overrun), 32'd0);
      for (int c = 0; c < 5; c++) begin
        idle(1);
        check("hold_valid", 32'(bus.dout_valid), 32'd1);
        check("hold_dout", 32'(bus.dout), 32'(sb[0]));
      end
      accept();
    end

    // Overrun: B arrives while A is still held and not accepted.
    send_word(4'b0011, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    sb.push_back(4'b0011);
    send_word(4'b1100, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("ovr_dout", 32'(bus.dout), 32'h3);
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    check("ovr_valid", 32'(bus.dout_valid), 32'd1);
    accept();
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    check("clear_overrun", 32'(bus.overrun), 32'd0);

    // Back-to-back: A consumed on the same edge that completes B.
    send_word(4'b0011, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    sb.push_back(4'b0011);
    for (int i = 0; i < W - 1; i++) begin
      logic [W-1:0] b_bits;
      b_bits = 4'b1100;
      send_bit(b_bits[W-1-i], 1'b1, 1'b0);
      check("b2b_valid_mid", 32'(bus.dout_valid), 32'd1);
    end
    check("b2b_old_dout", 32'(bus.dout), 32'(sb.pop_front()));
    send_bit(1'b0, 1'b1, 1'b1);
    sb.push_back(4'b1100);
    check("b2b_valid", 32'(bus.dout_valid), 32'd1);
    check("b2b_dout", 32'(bus.dout), 32'(sb[0]));
    check("b2b_overrun", 32'(bus.overrun), 32'd0);
    accept();

    // Asynchronous reset between edges in the middle of a word.
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_dout", 32'(bus.dout), 32'd0);
    check("arst_valid", 32'(bus.dout_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_overrun", 32'(bus.overrun), 32'd0);
    #3;
    reset_n = 1'b1;
    send_word(4'b0110, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    sb.push_back(4'b0110);
    check("arst_word", 32'(bus.dout), 32'(sb[0]));
    accept();

    // Synchronous clear with sin_valid high: that bit must be discarded.
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus.clear     = 1'b1;
    bus.sin       = 1'b1;
    bus.sin_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.clear     = 1'b0;
    bus.sin_valid = 1'b0;
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_dout", 32'(bus.dout), 32'd0);
    check("clr_valid", 32'(bus.dout_valid), 32'd0);
    send_word(4'b0110, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    sb.push_back(4'b0110);
    check("clr_word", 32'(bus.dout), 32'(sb[0]));
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
